// File: rtl/muldiv_pkg.sv
// muldiv shared types: op encoding, FSM state codes
// and small op-class helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t MD_IDLE = 2'd0;
  localparam muldiv_state_t MD_BUSY = 2'd1;
  localparam muldiv_state_t MD_DONE = 2'd2;

  function automatic logic op_is_mul(muldiv_op_t op);
    return ~op[2];
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic op_a_signed(muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_MULHSU) || (op == MD_DIV) ||
           (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv request/response bundle with valid/ready
// handshakes; master drives requests, slave is the unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             i_valid;
  logic             o_ready;
  muldiv_op_t       i_op;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_valid, i_op, i_op_a, i_op_b,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_op_a, i_op_b,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_result
  );

endinterface

// File: rtl/muldiv.sv
// Iterative mul/div: one shift-add or restoring step
// per cycle on a shared acc/quo register pair.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t    state;
  logic [CW-1:0]    cnt;
  muldiv_op_t       op_q;
  logic             neg_q;
  logic             rneg_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic             valid_q;
  logic [WIDTH-1:0] res_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             spec_hit;
  logic [WIDTH-1:0] spec_res;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   quo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;
  logic [WIDTH-1:0]   fix_res;

  assign bus.o_ready  = (state == MD_IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = res_q;

  assign accept = bus.i_valid & (state == MD_IDLE)
                & ~bus.i_flush;

  // operand magnitudes and sign flags for the accept edge
  always_comb begin
    a_neg = op_a_signed(bus.i_op) & bus.i_op_a[WIDTH-1];
    b_neg = op_b_signed(bus.i_op) & bus.i_op_b[WIDTH-1];
    a_mag = a_neg ? -bus.i_op_a : bus.i_op_a;
    b_mag = b_neg ? -bus.i_op_b : bus.i_op_b;
  end

  // results that need no iteration
  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (op_is_mul(bus.i_op)) begin
      if (ZERO_BYPASS &&
          (bus.i_op_a == '0 || bus.i_op_b == '0)) begin
        spec_hit = 1'b1;
      end
    end else if (bus.i_op_b == '0) begin
      spec_hit = 1'b1;
      spec_res = op_is_rem(bus.i_op) ? bus.i_op_a : '1;
    end else if ((bus.i_op == MD_DIV ||
                  bus.i_op == MD_REM) &&
                 bus.i_op_a == MIN_NEG &&
                 bus.i_op_b == '1) begin
      spec_hit = 1'b1;
      spec_res = (bus.i_op == MD_DIV) ? bus.i_op_a : '0;
    end
  end

  // one multiply or divide bit-step
  always_comb begin
    sum  = {1'b0, acc[WIDTH-1:0]}
         + (quo[0] ? {1'b0, dsr} : '0);
    shl  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    diff = {1'b0, shl} - {2'b00, dsr};
    if (op_is_mul(op_q)) begin
      acc_n = {1'b0, sum[WIDTH:1]};
      quo_n = {sum[0], quo[WIDTH-1:1]};
    end else if (diff[WIDTH+1]) begin
      acc_n = shl;
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end else begin
      acc_n = diff[WIDTH:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // sign fixup and result select on the last step
  always_comb begin
    prod   = {acc_n[WIDTH-1:0], quo_n};
    prod_f = neg_q ? -prod : prod;
    quo_f  = neg_q ? -quo_n : quo_n;
    rem_f  = rneg_q ? -acc_n[WIDTH-1:0]
                    : acc_n[WIDTH-1:0];
    fix_res = '0;
    unique case (1'b1)
      op_q == MD_MUL:
        fix_res = prod_f[WIDTH-1:0];
      op_is_mul(op_q) && op_q != MD_MUL:
        fix_res = prod_f[2*WIDTH-1:WIDTH];
      op_q == MD_DIV || op_q == MD_DIVU:
        fix_res = quo_f;
      op_is_rem(op_q):
        fix_res = rem_f;
      default:
        fix_res = '0;
    endcase
  end

  // FSM, datapath registers and registered output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc     <= '0;
      quo     <= '0;
      dsr     <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (bus.i_flush) begin
      state   <= MD_IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (accept) begin
            op_q   <= bus.i_op;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt    <= CW'(WIDTH - 1);
            acc    <= '0;
            if (spec_hit) begin
              state <= MD_DONE;
              res_q <= spec_res;
            end else begin
              state <= MD_BUSY;
              if (op_is_mul(bus.i_op)) begin
                dsr <= a_mag;
                quo <= b_mag;
              end else begin
                dsr <= b_mag;
                quo <= a_mag;
              end
            end
          end
        end
        MD_BUSY: begin
          acc <= acc_n;
          quo <= quo_n;
          if (cnt == '0) begin
            state   <= MD_DONE;
            valid_q <= 1'b1;
            res_q   <= fix_res;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        MD_DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.i_ready) begin
            valid_q <= 1'b0;
            state   <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: vector table plus
// backpressure, flush and async-reset sequences.
module tb_muldiv;
  import muldiv_pkg::*;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv #(
    .WIDTH(32),
    .ZERO_BYPASS(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start(muldiv_op_t op, logic [31:0] a,
                       logic [31:0] b);
    chk("ready_before", 32'(bus.o_ready), 32'd1);
    bus.i_op    = op;
    bus.i_op_a  = a;
    bus.i_op_b  = b;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_op    = MD_REMU;
    bus.i_op_a  = $urandom;
    bus.i_op_b  = $urandom;
    chk("ready_after", 32'(bus.o_ready), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.o_valid) break;
      if (lat > 200) begin
        total++;
        bad++;
        $display("FAIL timeout: got no o_valid want o_valid");
        lat = -1;
        break;
      end
    end
  endtask

  task automatic handoff();
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    chk("valid_drop", 32'(bus.o_valid), 32'd0);
    chk("ready_back", 32'(bus.o_ready), 32'd1);
  endtask

  task automatic run(vec_t v);
    int lat;
    start(v.op, v.a, v.b);
    wait_valid(lat);
    chk($sformatf("lat_%s", v.op.name()), lat, v.lat);
    chk($sformatf("res_%s", v.op.name()), bus.o_result,
        v.exp);
    handoff();
  endtask

  initial begin
    int   lat;
    logic seen;
    total = 0;
    bad   = 0;
    vecs.push_back('{MD_MUL, 32'd7, 32'hFFFFFFFD,
                     32'hFFFFFFEB, 32});
    vecs.push_back('{MD_MULH, 32'h80000000, 32'h80000000,
                     32'h40000000, 32});
    vecs.push_back('{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFF, 32});
    vecs.push_back('{MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32});
    vecs.push_back('{MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h00000001, 32});
    vecs.push_back('{MD_MULH, 32'hFFFFFFFF, 32'd5,
                     32'hFFFFFFFF, 32});
    vecs.push_back('{MD_DIV, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFD, 32});
    vecs.push_back('{MD_REM, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32});
    vecs.push_back('{MD_DIVU, 32'd100, 32'd7,
                     32'd14, 32});
    vecs.push_back('{MD_REMU, 32'd100, 32'd7,
                     32'd2, 32});
    vecs.push_back('{MD_DIV, 32'd7, 32'hFFFFFFFE,
                     32'hFFFFFFFD, 32});
    vecs.push_back('{MD_REM, 32'd7, 32'hFFFFFFFE,
                     32'd1, 32});
    vecs.push_back('{MD_DIVU, 32'hFFFFFFFF, 32'd1,
                     32'hFFFFFFFF, 32});
    vecs.push_back('{MD_DIV, 32'd5, 32'd0,
                     32'hFFFFFFFF, 1});
    vecs.push_back('{MD_REMU, 32'd5, 32'd0,
                     32'd5, 1});
    vecs.push_back('{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                     32'h80000000, 1});
    vecs.push_back('{MD_REM, 32'h80000000, 32'hFFFFFFFF,
                     32'd0, 1});
    vecs.push_back('{MD_MUL, 32'd0, 32'd1234,
                     32'd0, 1});

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_op    = MD_MUL;
    bus.i_op_a  = '0;
    bus.i_op_b  = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run(vecs[i]);

    // backpressure, then a request waiting on the handoff
    start(MD_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    chk("bp_lat", lat, 32'd32);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_result", bus.o_result, 32'd14);
      chk("bp_ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_op    = MD_MUL;
    bus.i_op_a  = 32'd3;
    bus.i_op_b  = 32'd4;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    chk("bp_drop", 32'(bus.o_valid), 32'd0);
    chk("bp_ready_up", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("bp_accept2", 32'(bus.o_ready), 32'd0);
    wait_valid(lat);
    chk("bp2_lat", lat, 32'd32);
    chk("bp2_result", bus.o_result, 32'd12);
    handoff();

    // flush on the tenth busy cycle
    start(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("fl_ready", 32'(bus.o_ready), 32'd1);
    chk("fl_valid", 32'(bus.o_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | bus.o_valid;
    end
    chk("fl_never_valid", 32'(seen), 32'd0);
    run('{MD_DIVU, 32'd9, 32'd3, 32'd3, 32});

    // async reset in the middle of a multiply
    start(MD_MUL, 32'd7, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.o_valid), 32'd0);
    chk("ar_result", bus.o_result, 32'd0);
    chk("ar_ready", 32'(bus.o_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run('{MD_MUL, 32'd7, 32'd3, 32'd21, 32});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
